// File: rtl/divisor_tick_gen.sv
// Multi-channel programmable tick generator with a free-running display-select prescaler.
// Optional square-wave outputs are built only when DIVISOR_SQUARE_OUT_EN is defined.
module divisor_tick_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 22,
  parameter int SEL_W  = 17
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic                    sel
);

  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  div_q   [NUM_CH];
  logic [CNT_W-1:0]  div_d   [NUM_CH];
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic [SEL_W-1:0]  presc_q;
  logic [SEL_W-1:0]  presc_d;
`ifdef DIVISOR_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_q;
  logic [NUM_CH-1:0] sq_d;
`endif

  // The divisor is re-latched only at terminal count, so a smaller new value
  // can never strand the counter above its compare point.
  always_comb begin
    tick_d  = '0;
    presc_d = presc_q + SEL_W'(1);
`ifdef DIVISOR_SQUARE_OUT_EN
    sq_d    = sq_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      if (ch_en[i]) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]  = '0;
          div_d[i]  = div_val[i*CNT_W +: CNT_W];
          tick_d[i] = 1'b1;
`ifdef DIVISOR_SQUARE_OUT_EN
          sq_d[i]   = ~sq_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= div_val[i*CNT_W +: CNT_W];
      end
      tick_q  <= '0;
      presc_q <= '0;
`ifdef DIVISOR_SQUARE_OUT_EN
      sq_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      tick_q  <= tick_d;
      presc_q <= presc_d;
`ifdef DIVISOR_SQUARE_OUT_EN
      sq_q    <= sq_d;
`endif
    end
  end

  assign tick = tick_q;
  assign sel  = presc_q[SEL_W-1];
`ifdef DIVISOR_SQUARE_OUT_EN
  assign sq   = sq_q;
`else
  assign sq   = '0;
`endif

endmodule

// File: tb/tb_divisor_tick_gen.sv
// Self-checking bench for divisor_tick_gen: directed scenarios plus randomized traffic
// compared against a countdown-style reference model.
module tb_divisor_tick_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 4;

  logic                    clock;
  logic                    reset;
  logic [NUM_CH-1:0]       chEn;
  logic [NUM_CH*CNT_W-1:0] divVal;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;
  logic                    sel;

  int checks = 0;
  int errors = 0;

  // Reference model: edges remaining until the next tick on each channel.
  int remEdges [NUM_CH];
  bit [NUM_CH-1:0] expTick;
  bit [NUM_CH-1:0] expSq;
  int presc;

  divisor_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .ch_en   (chEn),
    .div_val (divVal),
    .tick    (tick),
    .sq      (sq),
    .sel     (sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int sliceOf(input int ch);
    return int'(divVal[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic setDiv(input int ch, input int value);
    divVal[ch*CNT_W +: CNT_W] = CNT_W'(value);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: update the model from the inputs sampled at that edge, then compare.
  task automatic applyStimulus();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) remEdges[i] = sliceOf(i) + 1;
      expTick = '0;
      expSq   = '0;
      presc   = 0;
    end else begin
      presc = (presc + 1) % (1 << SEL_W);
      for (int i = 0; i < NUM_CH; i++) begin
        expTick[i] = 1'b0;
        if (chEn[i]) begin
          remEdges[i]--;
          if (remEdges[i] == 0) begin
            expTick[i]  = 1'b1;
            expSq[i]    = ~expSq[i];
            remEdges[i] = sliceOf(i) + 1;
          end
        end
      end
    end
    #1;
    checkOutput("tick", 32'(tick), 32'(expTick));
    checkOutput("sel", 32'(sel), 32'(presc >= (1 << (SEL_W - 1))));
`ifdef DIVISOR_SQUARE_OUT_EN
    checkOutput("sq", 32'(sq), 32'(expSq));
`else
    checkOutput("sq", 32'(sq), 32'(0));
`endif
  endtask

  task automatic doReset(input int d0, input int d1);
    reset = 1'b1;
    chEn  = '0;
    setDiv(0, d0);
    setDiv(1, d1);
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    chEn   = '0;
    divVal = '0;

    // Basic periods and reset state
    doReset(3, 9);
    checkOutput("reset_tick", 32'(tick), 32'(0));
    checkOutput("reset_sel", 32'(sel), 32'(0));
    checkOutput("reset_sq", 32'(sq), 32'(0));
    chEn = 2'b11;
    for (int e = 1; e <= 24; e++) begin
      applyStimulus();
      checkOutput("dir_tick0", 32'(tick[0]), 32'(e % 4 == 0));
      checkOutput("dir_tick1", 32'(tick[1]), 32'(e % 10 == 0));
    end

    // Divisor zero: continuous tick
    doReset(0, 5);
    chEn = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus();
      checkOutput("div0_tick", 32'(tick[0]), 32'(1));
    end

    // Divisor shrunk mid-period
    doReset(7, 2);
    chEn = 2'b11;
    repeat (5) applyStimulus();
    setDiv(0, 2);
    for (int e = 6; e <= 17; e++) begin
      applyStimulus();
      checkOutput("shrink_tick0", 32'(tick[0]), 32'(e == 8 || e == 11 || e == 14 || e == 17));
    end

    // Enable gap at cnt0 = 2
    doReset(4, 3);
    chEn = 2'b11;
    repeat (2) applyStimulus();
    chEn[0] = 1'b0;
    repeat (3) applyStimulus();
    chEn[0] = 1'b1;
    for (int e = 6; e <= 14; e++) begin
      applyStimulus();
      checkOutput("gap_tick0", 32'(tick[0]), 32'(e == 8 || e == 13));
    end

    // Reset one cycle before a terminal
    doReset(3, 3);
    chEn = 2'b11;
    repeat (3) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("midrst_tick", 32'(tick), 32'(0));
    checkOutput("midrst_sel", 32'(sel), 32'(0));
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      applyStimulus();
      checkOutput("postrst_tick0", 32'(tick[0]), 32'(e == 4));
    end

    // All-ones divisor on channel 1
    doReset(1, (1 << CNT_W) - 1);
    chEn = 2'b11;
    for (int e = 1; e <= (1 << CNT_W) + 2; e++) begin
      applyStimulus();
      checkOutput("max_tick1", 32'(tick[1]), 32'(e == (1 << CNT_W)));
    end

    // Randomized traffic
    doReset(2, 5);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_CH; i++) chEn[i] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) setDiv($urandom_range(0, NUM_CH - 1), $urandom_range(0, 12));
      reset = ($urandom_range(0, 79) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
